// File: rtl/soda_pkg.sv
// soda_pkg: shared state encoding, coin constants and coin legality helper
package soda_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_50 = 8'd50;
  localparam logic [7:0] COIN_100 = 8'd100;
  localparam logic [7:0] CREDIT_MAX = 8'd255;
  function automatic logic is_coin(input logic [7:0] v);
    return v == COIN_10 || v == COIN_50 || v == COIN_100;
  endfunction
endpackage

// File: rtl/change_sel.sv
// change_sel: largest change coin not exceeding the given credit, 0 when credit is 0
module change_sel
  import soda_pkg::*;
(
  input  logic [7:0] tot,
  output logic [7:0] coin
);
  always_comb coin = tot >= COIN_100 ? COIN_100 : tot >= COIN_50 ? COIN_50 : tot >= COIN_10 ? COIN_10 : 8'd0;
endmodule

// File: rtl/soda_vend_ctrl.sv
// soda_vend_ctrl: coin credit accumulation, single-cycle dispense and coin-by-coin change payout
module soda_vend_ctrl
  import soda_pkg::*;
#(
  parameter int PRICE = 150
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [7:0] coin_val,
  input  logic       cancel,
  input  logic       chg_ready,
  output logic [7:0] tot,
  output logic       d,
  output logic       coin_reject,
  output logic       chg_valid,
  output logic [7:0] chg_val,
  output logic       busy
);
  if (PRICE % 10 != 0 || PRICE < 10 || PRICE > 250) begin : g_bad_price
    $error("soda_vend_ctrl: PRICE must be a multiple of 10 in 10..250");
  end
  localparam logic [7:0] PRICE_L = 8'(PRICE);
  state_t state;
  logic [8:0] sum;
  logic [7:0] rem, sel_in, next_coin;
  logic accept;
  always_comb begin
    sum = {1'b0, tot} + {1'b0, coin_val};
    accept = coin_valid && is_coin(coin_val) && sum <= {1'b0, CREDIT_MAX} &&
             (state == IDLE || (state == ACCUM && tot < PRICE_L && !cancel));
    rem = state == VEND ? tot - PRICE_L : tot - chg_val;
    sel_in = state == ACCUM ? tot : rem;
  end
  change_sel u_change_sel (.tot(sel_in), .coin(next_coin));
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
      tot <= '0;
      d <= 1'b0;
      coin_reject <= 1'b0;
      chg_valid <= 1'b0;
      chg_val <= '0;
      busy <= 1'b0;
    end else begin
      d <= 1'b0;
      coin_reject <= coin_valid && !accept;
      case (state)
        IDLE: if (accept) begin
          tot <= sum[7:0];
          state <= ACCUM;
        end
        ACCUM: if (tot >= PRICE_L) begin
          state <= VEND;
          d <= 1'b1;
          busy <= 1'b1;
        end else if (cancel) begin
          state <= CHANGE;
          chg_valid <= 1'b1;
          chg_val <= next_coin;
          busy <= 1'b1;
        end else if (accept) tot <= sum[7:0];
        VEND: begin
          tot <= rem;
          state <= rem != 0 ? CHANGE : IDLE;
          chg_valid <= rem != 0;
          chg_val <= next_coin;
          busy <= rem != 0;
        end
        CHANGE: if (chg_ready) begin
          tot <= rem;
          chg_val <= next_coin;
          state <= rem != 0 ? CHANGE : IDLE;
          chg_valid <= rem != 0;
          busy <= rem != 0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soda_vend_ctrl.sv
// tb_soda_vend_ctrl: directed checks of credit, dispense, refund and change handshake
module tb_soda_vend_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_valid = 1'b0, cancel = 1'b0, chg_ready = 1'b0;
  logic [7:0] coin_val = '0;
  logic [7:0] tot, chg_val;
  logic d, coin_reject, chg_valid, busy;
  logic coin_valid2 = 1'b0, cancel2 = 1'b0, chg_ready2 = 1'b0;
  logic [7:0] coin_val2 = '0;
  logic [7:0] tot2, chg_val2;
  logic d2, coin_reject2, chg_valid2, busy2;
  int checks = 0, errors = 0, d_cnt = 0;
  always #5 clk = ~clk;
  soda_vend_ctrl #(.PRICE(150)) u150 (
    .sys_clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
    .cancel(cancel), .chg_ready(chg_ready), .tot(tot), .d(d), .coin_reject(coin_reject),
    .chg_valid(chg_valid), .chg_val(chg_val), .busy(busy)
  );
  soda_vend_ctrl #(.PRICE(250)) u250 (
    .sys_clk(clk), .reset(reset), .coin_valid(coin_valid2), .coin_val(coin_val2),
    .cancel(cancel2), .chg_ready(chg_ready2), .tot(tot2), .d(d2), .coin_reject(coin_reject2),
    .chg_valid(chg_valid2), .chg_val(chg_val2), .busy(busy2)
  );
  always @(negedge clk) if (d) d_cnt++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_val = v;
    tick;
    coin_valid = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_tot", tot, 0);
    chk("rst_d", d, 0);
    chk("rst_chg_valid", chg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject", coin_reject, 0);
    coin(8'd100);
    chk("t1_tot100", tot, 100);
    coin(8'd50);
    chk("t1_tot150", tot, 150);
    chk("t1_no_d_yet", d, 0);
    tick;
    chk("t1_d", d, 1);
    chk("t1_busy", busy, 1);
    tick;
    chk("t1_d_off", d, 0);
    chk("t1_idle_tot", tot, 0);
    chk("t1_no_chg", chg_valid, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_d_count", d_cnt, 1);
    coin(8'd100);
    coin(8'd100);
    chk("t2_tot200", tot, 200);
    tick;
    chk("t2_d", d, 1);
    tick;
    chk("t2_tot50", tot, 50);
    chk("t2_chg_valid", chg_valid, 1);
    chk("t2_chg_val", chg_val, 50);
    chk("t2_d_off", d, 0);
    chg_ready = 1'b1;
    tick;
    chg_ready = 1'b0;
    chk("t2_tot0", tot, 0);
    chk("t2_chg_done", chg_valid, 0);
    chk("t2_busy_off", busy, 0);
    coin(8'd50);
    chk("t3_tot50", tot, 50);
    coin(8'd25);
    chk("t3_reject", coin_reject, 1);
    chk("t3_tot_kept", tot, 50);
    tick;
    chk("t3_reject_off", coin_reject, 0);
    coin(8'd10);
    chk("t5_tot60", tot, 60);
    cancel = 1'b1;
    coin_valid = 1'b1;
    coin_val = 8'd10;
    tick;
    cancel = 1'b0;
    coin_valid = 1'b0;
    chk("t5_cancel_reject", coin_reject, 1);
    chk("t5_chg_valid", chg_valid, 1);
    chk("t5_tot60_kept", tot, 60);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_val", chg_val, 50);
      chk("t5_hold_valid", chg_valid, 1);
      tick;
    end
    chg_ready = 1'b1;
    tick;
    chk("t5_tot10", tot, 10);
    chk("t5_val10", chg_val, 10);
    chk("t5_valid_still", chg_valid, 1);
    tick;
    chg_ready = 1'b0;
    chk("t5_tot0", tot, 0);
    chk("t5_valid_off", chg_valid, 0);
    chk("t5_no_dispense", d_cnt, 2);
    coin(8'd100);
    coin(8'd100);
    tick;
    tick;
    chk("t6_in_change", chg_valid, 1);
    coin(8'd10);
    chk("t6_change_reject", coin_reject, 1);
    chk("t6_tot50", tot, 50);
    reset = 1'b1;
    chg_ready = 1'b1;
    tick;
    reset = 1'b0;
    chg_ready = 1'b0;
    chk("t6_rst_valid", chg_valid, 0);
    chk("t6_rst_tot", tot, 0);
    chk("t6_rst_busy", busy, 0);
    coin(8'd10);
    chk("t6_idle_accept", tot, 10);
    coin_valid2 = 1'b1;
    coin_val2 = 8'd100;
    tick;
    chk("t4_tot100", tot2, 100);
    tick;
    chk("t4_tot200", tot2, 200);
    tick;
    chk("t4_overflow_reject", coin_reject2, 1);
    chk("t4_tot_kept", tot2, 200);
    coin_val2 = 8'd50;
    tick;
    coin_valid2 = 1'b0;
    chk("t4_tot250", tot2, 250);
    chk("t4_reject_off", coin_reject2, 0);
    tick;
    chk("t4_d", d2, 1);
    tick;
    chk("t4_idle", tot2, 0);
    chk("t4_no_chg", chg_valid2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
